// File: rtl/seq_detect_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_detect_arb
// Description : Two-requester round-robin arbiter feeding an 8-bit frame,
//               MSB first, into a 4-bit overlapping pattern detector.
//               Counts matches per frame and flags end of frame.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_arb (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic       cfg_load,
  input  logic [3:0] cfg_pattern,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       ser_bit,
  output logic       out,
  output logic [2:0] match_cnt,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] shift_reg;
  logic [3:0] history;
  logic [3:0] pattern;
  logic [2:0] bit_cnt;
  logic       last_gnt;     // index of the requester granted most recently

  logic       pick;         // requester index chosen for the next grant
  logic [3:0] history_next;
  logic       hit;

  // Serial bit is only meaningful while shifting; forced low otherwise.
  assign ser_bit = (state == SHIFT) ? shift_reg[7] : 1'b0;
  assign busy    = (state != IDLE);

  // Round-robin choice and match detection on the history after this edge.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_gnt;
    end else begin
      pick = req[1];
    end
    history_next = {history[2:0], ser_bit};
    // bit_cnt counts bits already consumed, so >= 3 means this edge takes the
    // 4th or later bit of the frame and the history is entirely in-frame.
    hit = (history_next == pattern) && (bit_cnt >= 3'd3);
  end

  // Frame FSM with all outputs and datapath registers updated together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      out       <= 1'b0;
      done      <= 1'b0;
      match_cnt <= 3'd0;
      history   <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      pattern   <= 4'b1011;
      last_gnt  <= 1'b1;
    end else begin
      out  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A pattern loaded here is already in force for a frame granted
          // at the same edge, since matching only starts in SHIFT.
          if (cfg_load) begin
            pattern <= cfg_pattern;
          end
          if (|req) begin
            state     <= SHIFT;
            gnt       <= pick ? 2'b10 : 2'b01;
            last_gnt  <= pick;
            shift_reg <= pick ? data1 : data0;
            match_cnt <= 3'd0;
            history   <= 4'd0;
            bit_cnt   <= 3'd0;
          end
        end
        SHIFT: begin
          history   <= history_next;
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
          if (hit) begin
            out <= 1'b1;
            // At most five matches fit in a frame; the guard only keeps the
            // counter from ever wrapping.
            if (match_cnt != 3'd7) begin
              match_cnt <= match_cnt + 3'd1;
            end
          end
          if (bit_cnt == 3'd7) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_arb
// Description : Self-checking bench for seq_detect_arb. Each frame is captured
//               over ten cycles after its grant edge and compared against a
//               per-frame signature computed from the data byte and pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [1:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic       ser_bit;
  logic       out;
  logic [2:0] match_cnt;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference state: active pattern and last granted requester index.
  logic [3:0] m_pat;
  logic       m_last;

  // Per-cycle view of one frame; bit k is cycle k after the grant edge
  // (cycles 1..8 shift, 9 done, 10 idle). Bit 0 is unused.
  typedef struct packed {
    logic [1:0]  g1;
    logic [10:0] gon;
    logic [10:0] bsy;
    logic [10:0] dn;
    logic [10:0] o;
    logic [10:0] ser;
  } sig_t;

  sig_t       obs;
  logic [2:0] obs_cnt9;
  logic [2:0] obs_cnt10;

  always #5 clk = ~clk;

  seq_detect_arb dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .gnt        (gnt),
    .ser_bit    (ser_bit),
    .out        (out),
    .match_cnt  (match_cnt),
    .done       (done),
    .busy       (busy)
  );

  // Expected frame: every 4-bit window ending at bit i (i >= 3) that equals
  // the pattern yields an out pulse two cycles after that bit is presented.
  function automatic sig_t model_frame(input logic [7:0] d, input logic [3:0] p,
                                       input logic [1:0] g);
    sig_t s;
    s     = '0;
    s.g1  = g;
    s.gon = 11'b011_1111_1110;
    s.bsy = 11'b011_1111_1110;
    s.dn  = 11'b010_0000_0000;
    for (int k = 1; k <= 8; k++) s.ser[k] = d[8-k];
    for (int i = 3; i <= 7; i++) begin
      if (((d >> (7 - i)) & 8'h0F) == {4'h0, p}) s.o[i+2] = 1'b1;
    end
    return s;
  endfunction

  function automatic string sig2str(input sig_t s);
    return $sformatf("g1=%b gnt_on=%b busy=%b done=%b out=%b ser=%b",
                     s.g1, s.gon, s.bsy, s.dn, s.o, s.ser);
  endfunction

  // Present a request at an idle negedge and predict the resulting frame.
  task automatic start_frame(input logic [1:0] r, input logic [7:0] d0,
                             input logic [7:0] d1, output sig_t e,
                             output logic [2:0] ec);
    logic [1:0] g;
    req   = r;
    data0 = d0;
    data1 = d1;
    if (r == 2'b11) g = m_last ? 2'b01 : 2'b10;
    else            g = r;
    m_last = (g == 2'b10);
    e  = model_frame((g == 2'b10) ? d1 : d0, m_pat, g);
    ec = 3'($countones(e.o));
  endtask

  // Record ten cycles of outputs; after cycle 1 the request is changed and the
  // frame data scrambled, optionally with a pattern load attempted mid-shift.
  task automatic capture(input logic [1:0] req_after, input logic mid_cfg,
                         input logic [3:0] mid_pat);
    obs = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) obs.g1 = gnt;
      obs.gon[k] = (gnt != 2'b00);
      obs.bsy[k] = busy;
      obs.dn[k]  = done;
      obs.o[k]   = out;
      obs.ser[k] = ser_bit;
      if (k == 9)  obs_cnt9  = match_cnt;
      if (k == 10) obs_cnt10 = match_cnt;
      if (k == 1) begin
        cfg_load = 1'b0;
        req      = req_after;
        data0    = 8'($urandom);
        data1    = 8'($urandom);
      end
      if (k == 3 && mid_cfg) begin
        cfg_load    = 1'b1;
        cfg_pattern = mid_pat;
      end
      if (k == 4) cfg_load = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req      = 2'b00;
    cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_pat  = 4'b1011;
    m_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ser_bit !== 1'b0) begin errors++; $display("FAIL reset_ser got %b want 0", ser_bit); end
    checks++; if (match_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    m_pat  = 4'b1011;
    m_last = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, out, done, busy, ser_bit, match_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_release_idle got gnt=%b out=%b done=%b busy=%b ser=%b cnt=%0d want all zero",
               gnt, out, done, busy, ser_bit, match_cnt);
    end
  endtask

  task automatic test_basic();
    sig_t e; logic [2:0] ec;
    start_frame(2'b01, 8'b1011_0110, 8'h5A, e, ec);
    capture(2'b00, 1'b0, 4'h0);
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_frame got %s want %s", sig2str(obs), sig2str(e)); end
    checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL basic_cnt got %0d/%0d want %0d", obs_cnt9, obs_cnt10, ec); end
    repeat (3) @(negedge clk);
    checks++; if (match_cnt !== ec) begin errors++; $display("FAIL basic_cnt_hold got %0d want %0d", match_cnt, ec); end
  endtask

  task automatic test_pattern_ff();
    sig_t e; logic [2:0] ec;
    cfg_load    = 1'b1;
    cfg_pattern = 4'b1111;
    m_pat       = 4'b1111;
    @(negedge clk);
    cfg_load = 1'b0;
    start_frame(2'b10, 8'h00, 8'hFF, e, ec);
    capture(2'b00, 1'b0, 4'h0);
    checks++; if (obs !== e) begin errors++; $display("FAIL ff_frame got %s want %s", sig2str(obs), sig2str(e)); end
    checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL ff_cnt got %0d/%0d want %0d", obs_cnt9, obs_cnt10, ec); end
  endtask

  task automatic test_cfg_with_req();
    sig_t e; logic [2:0] ec;
    cfg_load    = 1'b1;
    cfg_pattern = 4'b0110;
    m_pat       = 4'b0110;
    start_frame(2'b01, 8'b0110_1100, 8'h00, e, ec);
    capture(2'b00, 1'b0, 4'h0);
    checks++; if (obs !== e) begin errors++; $display("FAIL cfgreq_frame got %s want %s", sig2str(obs), sig2str(e)); end
    checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL cfgreq_cnt got %0d/%0d want %0d", obs_cnt9, obs_cnt10, ec); end
  endtask

  task automatic test_back_to_back();
    sig_t e; logic [2:0] ec;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      start_frame(2'b11, 8'b1011_1011, 8'b0101_1011, e, ec);
      capture(2'b11, 1'b0, 4'h0);
      checks++; if (obs !== e) begin errors++; $display("FAIL rr_frame%0d got %s want %s", n, sig2str(obs), sig2str(e)); end
      checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL rr_cnt%0d got %0d/%0d want %0d", n, obs_cnt9, obs_cnt10, ec); end
    end
    req = 2'b00;
  endtask

  task automatic test_cfg_midshift();
    sig_t e; logic [2:0] ec;
    for (int n = 0; n < 2; n++) begin
      start_frame(2'b01, 8'h00, 8'h00, e, ec);
      capture(2'b00, (n == 0), 4'b0000);
      checks++; if (obs !== e) begin errors++; $display("FAIL midcfg_frame%0d got %s want %s", n, sig2str(obs), sig2str(e)); end
      checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL midcfg_cnt%0d got %0d/%0d want %0d", n, obs_cnt9, obs_cnt10, ec); end
    end
  endtask

  task automatic test_reset_midframe();
    sig_t e; logic [2:0] ec;
    int   done_seen;
    start_frame(2'b01, 8'b1011_1011, 8'h00, e, ec);
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b0;
    req = 2'b00;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt got %b want 00", gnt); end
    checks++; if (out !== 1'b0 || busy !== 1'b0 || ser_bit !== 1'b0) begin errors++; $display("FAIL midrst_outs got out=%b busy=%b ser=%b want 0/0/0", out, busy, ser_bit); end
    checks++; if (match_cnt !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL midrst_cnt got cnt=%0d done=%b want 0/0", match_cnt, done); end
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_pat  = 4'b1011;
    m_last = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1 || gnt !== 2'b00) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", done_seen); end
    start_frame(2'b01, 8'b1011_1011, 8'h00, e, ec);
    capture(2'b00, 1'b0, 4'h0);
    checks++; if (obs !== e) begin errors++; $display("FAIL midrst_frame got %s want %s", sig2str(obs), sig2str(e)); end
    checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL midrst_cnt_after got %0d/%0d want %0d", obs_cnt9, obs_cnt10, ec); end
  endtask

  task automatic test_no_cross_frame();
    sig_t e; logic [2:0] ec;
    logic [7:0] frames [2];
    frames[0] = 8'b0000_0101;
    frames[1] = 8'b1000_0000;
    for (int n = 0; n < 2; n++) begin
      start_frame(2'b01, frames[n], 8'h00, e, ec);
      capture(2'b00, 1'b0, 4'h0);
      checks++; if (obs !== e) begin errors++; $display("FAIL cross_frame%0d got %s want %s", n, sig2str(obs), sig2str(e)); end
      checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL cross_cnt%0d got %0d/%0d want %0d", n, obs_cnt9, obs_cnt10, ec); end
    end
  endtask

  task automatic test_random();
    sig_t e; logic [2:0] ec;
    logic [1:0] r;
    logic [7:0] d0, d1;
    logic       gap;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_load    = 1'b1;
        cfg_pattern = 4'($urandom);
        m_pat       = cfg_pattern;
      end
      r  = 2'($urandom_range(1, 3));
      d0 = ($urandom_range(0, 1) == 1) ? {m_pat, m_pat} : 8'($urandom);
      d1 = ($urandom_range(0, 1) == 1) ? {m_pat, m_pat} : 8'($urandom);
      start_frame(r, d0, d1, e, ec);
      gap = 1'($urandom_range(0, 1));
      capture(gap ? 2'b00 : 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
      checks++; if (obs !== e) begin errors++; $display("FAIL rand_frame%0d got %s want %s", n, sig2str(obs), sig2str(e)); end
      checks++; if (obs_cnt9 !== ec || obs_cnt10 !== ec) begin errors++; $display("FAIL rand_cnt%0d got %0d/%0d want %0d", n, obs_cnt9, obs_cnt10, ec); end
      if (gap) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    req = 2'b00;
  endtask

  initial begin
    cfg_load    = 1'b0;
    cfg_pattern = 4'h0;
    req         = 2'b00;
    data0       = 8'h00;
    data1       = 8'h00;
    m_pat       = 4'b1011;
    m_last      = 1'b1;
    test_reset();
    test_basic();
    test_pattern_ff();
    test_cfg_with_req();
    test_back_to_back();
    test_cfg_midshift();
    test_reset_midframe();
    test_no_cross_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_arb.md
SEQ_DETECT_ARB -- requirements
Module: seq_detect_arb

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: cfg_load  input  1  load cfg_pattern; honoured only in IDLE.
REQ-004 SHALL provide: cfg_pattern  input  4  detect pattern; bit 3 is the oldest bit.
REQ-005 SHALL provide: req  input  2  per-requester scan request; req[i] is held until done.
REQ-006 SHALL provide: data0 / data1  input  8 each  requester frames; sampled at grant.
REQ-007 SHALL provide: gnt  output  2  one-hot grant, registered.
REQ-008 SHALL provide: ser_bit  output  1  serial bit currently presented to the detector.
REQ-009 SHALL provide: out  output  1  registered one-cycle match pulse.
REQ-010 SHALL provide: match_cnt  output  3  matches in the current or last frame.
REQ-011 SHALL provide: done  output  1  one-cycle end-of-frame pulse.
REQ-012 SHALL provide: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE, any req bit high at an edge: SHALL move to SHIFT, set gnt, load the granted frame into an 8-bit shift register, clear match_cnt, the 4-bit history and the bit counter.
REQ-015 Arbitration SHALL be round-robin: both requests high -> grant the requester not granted last; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-016 In SHIFT, ser_bit SHALL equal shift-register bit 7 (MSB first); ser_bit = 0 outside SHIFT.
REQ-017 Each SHIFT edge SHALL:
- set history to {history[2:0], ser_bit};
- shift the shift register left by one;
- increment the bit counter (0..7).
REQ-018 A match SHALL be the new history equal to the pattern with at least 4 bits of the frame consumed.
- Overlapping matches count.
- No match spans two frames.
REQ-019 On a match edge, out SHALL be 1 for the following cycle and match_cnt SHALL increment by one at that same edge.
REQ-020 match_cnt SHALL NOT wrap; 5 is the maximum possible per frame (pattern 1111 on 8'hFF).
REQ-021 The edge consuming bit 7 SHALL move the FSM to DONE; a match on bit 7 shows on out during the DONE cycle.
REQ-022 DONE SHALL:
- last exactly one cycle, with done = 1 and gnt still held;
- leave match_cnt final;
- then return to IDLE with gnt = 00.
REQ-023 gnt SHALL be high for exactly 9 cycles per frame; a back-to-back grant SHALL occur no earlier than the edge after the IDLE cycle.
REQ-024 A req held through DONE SHALL be treated as a new request in IDLE, subject to round-robin.
REQ-025 A req bit dropped during SHIFT SHALL NOT abort the frame.
REQ-026 match_cnt SHALL hold its value through IDLE until the next grant edge.
REQ-027 cfg_load in IDLE SHALL update the pattern at that edge; cfg_load outside IDLE SHALL be ignored.
REQ-028 cfg_load and a req in the same IDLE cycle: the new frame SHALL use the newly loaded pattern.

Reset
REQ-029 rst = 0 SHALL immediately set all of the following, without waiting for clk:
- state IDLE, gnt 00, out 0, done 0, busy 0, ser_bit 0, match_cnt 0;
- history 0, bit counter 0, shift register 0;
- pattern 4'b1011, last-granted pointer 1.
REQ-030 Reset during SHIFT or DONE SHALL abandon the frame with no done pulse; after release, operation SHALL resume from IDLE.

Verification
REQ-031 Default pattern, req = 01, data0 = 8'b1011_0110 -> ser_bit sequence 1,0,1,1,0,1,1,0; out pulses after bits 3 and 6; match_cnt = 2; done 9 cycles after the grant edge.
REQ-032 cfg_load with cfg_pattern = 4'b1111, then req = 10, data1 = 8'hFF -> gnt = 10; 5 out pulses; match_cnt = 5; the last pulse coincides with done.
REQ-033 req = 11 held continuously -> gnt sequence 01, 10, 01, each lasting 9 cycles with one IDLE cycle between grants.
REQ-034 cfg_load with 4'b0000 asserted mid-SHIFT -> current and next frames still use the old pattern; data0 = 8'h00 gives match_cnt = 0.
REQ-035 rst low on the 4th SHIFT cycle -> gnt = 00 and out = 0 immediately; no done pulse; req = 01 after release -> a fresh 9-cycle frame.
REQ-036 Frame 1 data0 = 8'b0000_0101, frame 2 data0 = 8'b1000_0000 under pattern 1011 -> match_cnt = 0 for both frames (no cross-frame match).
